// File: rtl/fpu_issue_sched_pkg.sv
// Shared definitions for the FP issue scheduler: class encodings, default
// latencies, writeback slot type and the latency-by-class helper.
package fpu_sched_pkg;

   localparam logic [1:0] CLS_NOWB   = 2'b00;
   localparam logic [1:0] CLS_SINGLE = 2'b01;
   localparam logic [1:0] CLS_PIPE   = 2'b10;
   localparam logic [1:0] CLS_DIV    = 2'b11;

   localparam int unsigned DEF_PIPE_LAT = 3;
   localparam int unsigned DEF_DIV_LAT  = 12;

   typedef enum logic {
      DIV_IDLE = 1'b0,
      DIV_BUSY = 1'b1
   } div_state_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic [1:0] unit;
   } wb_slot_t;

   function automatic int unsigned class_latency(input logic [1:0] cls,
                                                 input int unsigned pipe_lat,
                                                 input int unsigned div_lat);
      case (cls)
         CLS_SINGLE: return 1;
         CLS_PIPE:   return pipe_lat;
         CLS_DIV:    return div_lat;
         default:    return 0;
      endcase
   endfunction

endpackage

// File: rtl/fpu_issue_sched_if.sv
// Decode-to-scheduler issue handshake plus the writeback/unit-start outputs.
interface fpu_issue_sched_if;

   logic       issue_valid;
   logic [1:0] issue_class;
   logic [4:0] issue_rd;
   logic [4:0] issue_rs1;
   logic [4:0] issue_rs2;
   logic [4:0] issue_rs3;
   logic       issue_use_rs1;
   logic       issue_use_rs2;
   logic       issue_use_rs3;
   logic       issue_ready;
   logic       pipe_start;
   logic       div_start;
   logic       div_busy;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic [1:0] wb_unit;

   modport master (
      output issue_valid, issue_class, issue_rd,
      output issue_rs1, issue_rs2, issue_rs3,
      output issue_use_rs1, issue_use_rs2, issue_use_rs3,
      input  issue_ready, pipe_start, div_start, div_busy,
      input  wb_valid, wb_rd, wb_unit
   );

   modport slave (
      input  issue_valid, issue_class, issue_rd,
      input  issue_rs1, issue_rs2, issue_rs3,
      input  issue_use_rs1, issue_use_rs2, issue_use_rs3,
      output issue_ready, pipe_start, div_start, div_busy,
      output wb_valid, wb_rd, wb_unit
   );

endinterface

// File: rtl/fpu_issue_sched_div_fsm.sv
// Occupancy tracker for the non-pipelined div/sqrt unit: IDLE/BUSY plus a
// down-counter that reaches zero in the writeback cycle.
module fpu_div_fsm
   import fpu_sched_pkg::*;
#(
   parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
   input  logic clk,
   input  logic reset,
   input  logic i_start,
   output logic o_busy
);

   localparam int unsigned CW = $clog2(DIV_LAT);

   div_state_e       r_state;
   div_state_e       w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= DIV_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         DIV_IDLE: begin
            if (i_start) begin
               w_state_nxt = DIV_BUSY;
               w_cnt_nxt   = CW'(DIV_LAT - 1);
            end
         end
         DIV_BUSY: begin
            if (r_cnt == '0) w_state_nxt = DIV_IDLE;
            else             w_cnt_nxt   = r_cnt - CW'(1);
         end
         default: w_state_nxt = DIV_IDLE;
      endcase
   end

   assign o_busy = (r_state == DIV_BUSY);

endmodule

// File: rtl/fpu_issue_sched.sv
// FP issue scheduler: scoreboard (RAW/WAW), write-port reservation slots and
// div occupancy decide issue_ready; writeback is scheduled entirely at issue.
module fpu_issue_sched
   import fpu_sched_pkg::*;
#(
   parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
   parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
   input  logic          clk,
   input  logic          reset,
   fpu_issue_sched_if.slave bus
);

   localparam int unsigned LW = $clog2(DIV_LAT + 1);

   logic [31:0]    r_busy;
   logic [31:0]    w_busy_nxt;
   wb_slot_t       r_slot     [1:DIV_LAT];
   wb_slot_t       w_slot_nxt [1:DIV_LAT];
   wb_slot_t       r_wb;
   wb_slot_t       w_wb_nxt;
   logic [DIV_LAT:0] w_res;
   logic [LW-1:0]  w_lat;
   logic           w_writes;
   logic           w_src_hit;
   logic           w_ready;
   logic           w_accept;
   logic           w_div_start;
   logic           w_div_busy;

   // Slot k holds the result that will own the write port k cycles from now.
   always_comb begin
      w_res = '0;
      for (int unsigned k = 1; k <= DIV_LAT; k++) w_res[k] = r_slot[k].valid;
   end

   assign w_lat     = LW'(class_latency(bus.issue_class, PIPE_LAT, DIV_LAT));
   assign w_writes  = (bus.issue_class != CLS_NOWB);
   assign w_src_hit = (bus.issue_use_rs1 && r_busy[bus.issue_rs1]) ||
                      (bus.issue_use_rs2 && r_busy[bus.issue_rs2]) ||
                      (bus.issue_use_rs3 && r_busy[bus.issue_rs3]);
   assign w_ready   = !w_src_hit &&
                      !(w_writes && (r_busy[bus.issue_rd] || w_res[w_lat])) &&
                      !((bus.issue_class == CLS_DIV) && w_div_busy);
   assign w_accept    = bus.issue_valid && w_ready;
   assign w_div_start = w_accept && (bus.issue_class == CLS_DIV);

   always_comb begin
      w_busy_nxt = r_busy;
      if (r_wb.valid) w_busy_nxt[r_wb.rd] = 1'b0;
      if (w_accept && w_writes) w_busy_nxt[bus.issue_rd] = 1'b1;

      for (int unsigned k = 1; k <= DIV_LAT; k++) w_slot_nxt[k] = '0;
      for (int unsigned k = 1; k < DIV_LAT; k++) w_slot_nxt[k] = r_slot[k + 1];
      // The res[L] check guarantees slot L-1 is empty after the shift.
      if (w_accept && (w_lat >= LW'(2)))
         w_slot_nxt[w_lat - LW'(1)] = {1'b1, bus.issue_rd, bus.issue_class};

      w_wb_nxt = r_slot[1];
      if (w_accept && (w_lat == LW'(1)))
         w_wb_nxt = {1'b1, bus.issue_rd, bus.issue_class};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= '0;
         r_wb   <= '0;
         for (int unsigned k = 1; k <= DIV_LAT; k++) r_slot[k] <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_wb   <= w_wb_nxt;
         for (int unsigned k = 1; k <= DIV_LAT; k++) r_slot[k] <= w_slot_nxt[k];
      end
   end

   fpu_div_fsm #(.DIV_LAT(DIV_LAT)) u_div_fsm (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_div_start),
      .o_busy  (w_div_busy)
   );

   assign bus.issue_ready = w_ready;
   assign bus.pipe_start  = w_accept && (bus.issue_class == CLS_PIPE);
   assign bus.div_start   = w_div_start;
   assign bus.div_busy    = w_div_busy;
   assign bus.wb_valid    = r_wb.valid;
   assign bus.wb_rd       = r_wb.rd;
   assign bus.wb_unit     = r_wb.unit;

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed-vector bench for fpu_issue_sched with PIPE_LAT=3, DIV_LAT=12.
module tb_fpu_issue_sched;
   import fpu_sched_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   fpu_issue_sched_if bus ();

   fpu_issue_sched #(.PIPE_LAT(3), .DIV_LAT(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic v, input logic [1:0] cls, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic u1);
      bus.issue_valid   = v;
      bus.issue_class   = cls;
      bus.issue_rd      = rd;
      bus.issue_rs1     = rs1;
      bus.issue_rs2     = 5'd0;
      bus.issue_rs3     = 5'd0;
      bus.issue_use_rs1 = u1;
      bus.issue_use_rs2 = 1'b0;
      bus.issue_use_rs3 = 1'b0;
   endtask

   task automatic idle;
      present(1'b0, CLS_NOWB, 5'd0, 5'd0, 1'b0);
   endtask

   // Leaves the bench at the start of cycle 0 with the DUT freshly reset.
   task automatic do_reset;
      idle();
      reset = 1'b1;
      next_cyc();
      next_cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      present(1'b1, CLS_DIV, 5'd8, 5'd0, 1'b0);
      next_cyc();
      idle();
      next_cyc();
      reset = 1'b1;
      next_cyc();
      next_cyc();
      reset = 1'b0;
      #2;
      vectors++;
      if (bus.wb_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset wb_valid got=%b exp=0", bus.wb_valid);
      end
      vectors++;
      if (bus.wb_rd !== 5'd0) begin
         miscompares++;
         $display("FAIL reset wb_rd got=%0d exp=0", bus.wb_rd);
      end
      vectors++;
      if (bus.wb_unit !== 2'd0) begin
         miscompares++;
         $display("FAIL reset wb_unit got=%0d exp=0", bus.wb_unit);
      end
      vectors++;
      if (bus.div_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset div_busy got=%b exp=0", bus.div_busy);
      end
      present(1'b0, CLS_DIV, 5'd9, 5'd8, 1'b1);
      #1;
      vectors++;
      if (bus.issue_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset issue_ready got=%b exp=1", bus.issue_ready);
      end
   endtask

   task automatic test_single;
      do_reset();
      present(1'b1, CLS_SINGLE, 5'd1, 5'd0, 1'b0);
      #2;
      vectors++;
      if (bus.issue_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL single ready t=0 got=%b exp=1", bus.issue_ready);
      end
      next_cyc();
      present(1'b0, CLS_SINGLE, 5'd9, 5'd1, 1'b1);
      #2;
      vectors++;
      if ({bus.wb_valid, bus.wb_rd, bus.wb_unit} !== {1'b1, 5'd1, 2'b01}) begin
         miscompares++;
         $display("FAIL single wb t=1 got=%b/%0d/%0d exp=1/1/1",
                  bus.wb_valid, bus.wb_rd, bus.wb_unit);
      end
      vectors++;
      if (bus.issue_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL single no_bypass t=1 got=%b exp=0", bus.issue_ready);
      end
      next_cyc();
      #2;
      vectors++;
      if (bus.issue_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL single busy_clear t=2 got=%b exp=1", bus.issue_ready);
      end
      vectors++;
      if (bus.wb_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single wb_valid t=2 got=%b exp=0", bus.wb_valid);
      end
   endtask

   task automatic test_raw;
      logic e_rdy, e_wv;
      logic [6:0] e_wb;
      do_reset();
      for (int t = 0; t <= 5; t++) begin
         if (t == 0)      present(1'b1, CLS_PIPE, 5'd2, 5'd0, 1'b0);
         else if (t <= 4) present(1'b1, CLS_SINGLE, 5'd4, 5'd2, 1'b1);
         else             idle();
         #2;
         e_rdy = (t == 0) || (t == 4);
         e_wv  = (t == 3) || (t == 5);
         e_wb  = (t == 3) ? {5'd2, 2'b10} : {5'd4, 2'b01};
         if (t <= 4) begin
            vectors++;
            if (bus.issue_ready !== e_rdy) begin
               miscompares++;
               $display("FAIL raw ready t=%0d got=%b exp=%b", t, bus.issue_ready, e_rdy);
            end
         end
         vectors++;
         if (bus.pipe_start !== (t == 0)) begin
            miscompares++;
            $display("FAIL raw pipe_start t=%0d got=%b exp=%b", t, bus.pipe_start, (t == 0));
         end
         vectors++;
         if (bus.wb_valid !== e_wv) begin
            miscompares++;
            $display("FAIL raw wb_valid t=%0d got=%b exp=%b", t, bus.wb_valid, e_wv);
         end
         if (e_wv) begin
            vectors++;
            if ({bus.wb_rd, bus.wb_unit} !== e_wb) begin
               miscompares++;
               $display("FAIL raw wb t=%0d got=%0d/%0d exp=%0d/%0d", t,
                        bus.wb_rd, bus.wb_unit, e_wb[6:2], e_wb[1:0]);
            end
         end
         next_cyc();
      end
   endtask

   task automatic test_div_res;
      logic e_wv;
      logic [6:0] e_wb;
      do_reset();
      for (int t = 0; t <= 13; t++) begin
         if (t == 0)                present(1'b1, CLS_DIV, 5'd5, 5'd0, 1'b0);
         else if (t == 9 || t == 10) present(1'b1, CLS_PIPE, 5'd6, 5'd0, 1'b0);
         else                       idle();
         #2;
         if (t == 0 || t == 9 || t == 10) begin
            vectors++;
            if (bus.issue_ready !== (t != 9)) begin
               miscompares++;
               $display("FAIL div_res ready t=%0d got=%b exp=%b", t, bus.issue_ready, (t != 9));
            end
         end
         vectors++;
         if (bus.div_start !== (t == 0)) begin
            miscompares++;
            $display("FAIL div_res div_start t=%0d got=%b exp=%b", t, bus.div_start, (t == 0));
         end
         vectors++;
         if (bus.pipe_start !== (t == 10)) begin
            miscompares++;
            $display("FAIL div_res pipe_start t=%0d got=%b exp=%b", t, bus.pipe_start, (t == 10));
         end
         vectors++;
         if (bus.div_busy !== (t >= 1 && t <= 12)) begin
            miscompares++;
            $display("FAIL div_res div_busy t=%0d got=%b exp=%b", t, bus.div_busy,
                     (t >= 1 && t <= 12));
         end
         e_wv = (t == 12) || (t == 13);
         e_wb = (t == 12) ? {5'd5, 2'b11} : {5'd6, 2'b10};
         vectors++;
         if (bus.wb_valid !== e_wv) begin
            miscompares++;
            $display("FAIL div_res wb_valid t=%0d got=%b exp=%b", t, bus.wb_valid, e_wv);
         end
         if (e_wv) begin
            vectors++;
            if ({bus.wb_rd, bus.wb_unit} !== e_wb) begin
               miscompares++;
               $display("FAIL div_res wb t=%0d got=%0d/%0d exp=%0d/%0d", t,
                        bus.wb_rd, bus.wb_unit, e_wb[6:2], e_wb[1:0]);
            end
         end
         next_cyc();
      end
   endtask

   task automatic test_back_to_back_div;
      logic e_bsy, e_wv;
      logic [6:0] e_wb;
      do_reset();
      for (int t = 0; t <= 26; t++) begin
         if (t == 0)       present(1'b1, CLS_DIV, 5'd5, 5'd0, 1'b0);
         else if (t <= 13) present(1'b1, CLS_DIV, 5'd7, 5'd0, 1'b0);
         else              idle();
         #2;
         if (t <= 13) begin
            vectors++;
            if (bus.issue_ready !== (t == 0 || t == 13)) begin
               miscompares++;
               $display("FAIL b2b_div ready t=%0d got=%b exp=%b", t, bus.issue_ready,
                        (t == 0 || t == 13));
            end
         end
         e_bsy = (t >= 1 && t <= 12) || (t >= 14 && t <= 25);
         vectors++;
         if (bus.div_busy !== e_bsy) begin
            miscompares++;
            $display("FAIL b2b_div div_busy t=%0d got=%b exp=%b", t, bus.div_busy, e_bsy);
         end
         e_wv = (t == 12) || (t == 25);
         e_wb = (t == 12) ? {5'd5, 2'b11} : {5'd7, 2'b11};
         vectors++;
         if (bus.wb_valid !== e_wv) begin
            miscompares++;
            $display("FAIL b2b_div wb_valid t=%0d got=%b exp=%b", t, bus.wb_valid, e_wv);
         end
         if (e_wv) begin
            vectors++;
            if ({bus.wb_rd, bus.wb_unit} !== e_wb) begin
               miscompares++;
               $display("FAIL b2b_div wb t=%0d got=%0d/%0d exp=%0d/%0d", t,
                        bus.wb_rd, bus.wb_unit, e_wb[6:2], e_wb[1:0]);
            end
         end
         next_cyc();
      end
   endtask

   task automatic test_waw;
      logic e_wv;
      logic [6:0] e_wb;
      do_reset();
      for (int t = 0; t <= 5; t++) begin
         if (t == 0)      present(1'b1, CLS_PIPE, 5'd3, 5'd0, 1'b0);
         else if (t <= 4) present(1'b1, CLS_SINGLE, 5'd3, 5'd0, 1'b0);
         else             idle();
         #2;
         if (t <= 4) begin
            vectors++;
            if (bus.issue_ready !== (t == 0 || t == 4)) begin
               miscompares++;
               $display("FAIL waw ready t=%0d got=%b exp=%b", t, bus.issue_ready,
                        (t == 0 || t == 4));
            end
         end
         e_wv = (t == 3) || (t == 5);
         e_wb = (t == 3) ? {5'd3, 2'b10} : {5'd3, 2'b01};
         vectors++;
         if (bus.wb_valid !== e_wv) begin
            miscompares++;
            $display("FAIL waw wb_valid t=%0d got=%b exp=%b", t, bus.wb_valid, e_wv);
         end
         if (e_wv) begin
            vectors++;
            if ({bus.wb_rd, bus.wb_unit} !== e_wb) begin
               miscompares++;
               $display("FAIL waw wb t=%0d got=%0d/%0d exp=%0d/%0d", t,
                        bus.wb_rd, bus.wb_unit, e_wb[6:2], e_wb[1:0]);
            end
         end
         next_cyc();
      end
   endtask

   // SINGLE colliding with an older PIPE claim on res[1]; NOWB ignores rd/res.
   task automatic test_port_conflict;
      logic e_rdy, e_wv;
      logic [6:0] e_wb;
      do_reset();
      for (int t = 0; t <= 5; t++) begin
         case (t)
            0:       present(1'b1, CLS_PIPE, 5'd10, 5'd0, 1'b0);
            1:       present(1'b1, CLS_SINGLE, 5'd11, 5'd0, 1'b0);
            2, 3:    present(1'b1, CLS_SINGLE, 5'd12, 5'd0, 1'b0);
            4:       present(1'b1, CLS_NOWB, 5'd12, 5'd0, 1'b0);
            default: idle();
         endcase
         #2;
         e_rdy = (t != 2);
         if (t <= 4) begin
            vectors++;
            if (bus.issue_ready !== e_rdy) begin
               miscompares++;
               $display("FAIL port ready t=%0d got=%b exp=%b", t, bus.issue_ready, e_rdy);
            end
         end
         e_wv = (t >= 2 && t <= 4);
         e_wb = (t == 2) ? {5'd11, 2'b01} : (t == 3) ? {5'd10, 2'b10} : {5'd12, 2'b01};
         vectors++;
         if (bus.wb_valid !== e_wv) begin
            miscompares++;
            $display("FAIL port wb_valid t=%0d got=%b exp=%b", t, bus.wb_valid, e_wv);
         end
         if (e_wv) begin
            vectors++;
            if ({bus.wb_rd, bus.wb_unit} !== e_wb) begin
               miscompares++;
               $display("FAIL port wb t=%0d got=%0d/%0d exp=%0d/%0d", t,
                        bus.wb_rd, bus.wb_unit, e_wb[6:2], e_wb[1:0]);
            end
         end
         next_cyc();
      end
   endtask

   task automatic test_reset_mid_div;
      logic e_bsy;
      do_reset();
      for (int t = 0; t <= 18; t++) begin
         reset = (t == 4 || t == 5);
         if (t == 0)      present(1'b1, CLS_DIV, 5'd8, 5'd0, 1'b0);
         else if (t == 6) present(1'b1, CLS_DIV, 5'd9, 5'd8, 1'b1);
         else             idle();
         #2;
         if (t == 6) begin
            vectors++;
            if (bus.issue_ready !== 1'b1) begin
               miscompares++;
               $display("FAIL mid_div ready t=6 got=%b exp=1", bus.issue_ready);
            end
            vectors++;
            if (bus.div_start !== 1'b1) begin
               miscompares++;
               $display("FAIL mid_div div_start t=6 got=%b exp=1", bus.div_start);
            end
         end
         e_bsy = (t >= 1 && t <= 4) || (t >= 7);
         vectors++;
         if (bus.div_busy !== e_bsy) begin
            miscompares++;
            $display("FAIL mid_div div_busy t=%0d got=%b exp=%b", t, bus.div_busy, e_bsy);
         end
         vectors++;
         if (bus.wb_valid !== (t == 18)) begin
            miscompares++;
            $display("FAIL mid_div wb_valid t=%0d got=%b exp=%b", t, bus.wb_valid, (t == 18));
         end
         if (t == 18) begin
            vectors++;
            if ({bus.wb_rd, bus.wb_unit} !== {5'd9, 2'b11}) begin
               miscompares++;
               $display("FAIL mid_div wb t=18 got=%0d/%0d exp=9/3", bus.wb_rd, bus.wb_unit);
            end
         end
         next_cyc();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_single();
      test_raw();
      test_div_res();
      test_back_to_back_div();
      test_waw();
      test_port_conflict();
      test_reset_mid_div();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
